// File: rtl/stage_wb_param.sv
// Write-back stage: W pipeline registers, load extraction/extension, link data,
// GRF write enable, retire counter and previous-retire history for bypassing.
module stage_wb_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_M,
  input  logic [31:0]       pc_M,
  input  logic              we_M,
  input  logic [RA_W-1:0]   a3_M,
  input  logic [1:0]        wd_src_M,
  input  logic [2:0]        ld_type_M,
  input  logic [DATA_W-1:0] ao_M,
  input  logic [DATA_W-1:0] dm_M,
  input  logic              stall_W,
  input  logic              flush_W,
  input  logic              clr_cnt,
  output logic [RA_W-1:0]   A3_W,
  output logic [DATA_W-1:0] WD3_W,
  output logic              grf_we_W,
  output logic              valid_W,
  output logic [RA_W-1:0]   A3_H,
  output logic [DATA_W-1:0] WD3_H,
  output logic              we_H,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned LaneW = $clog2(DATA_W / 8);

  logic              valid_q;
  logic [31:0]       pc_q;
  logic              we_q;
  logic [RA_W-1:0]   a3_q;
  logic [1:0]        wd_src_q;
  logic [2:0]        ld_type_q;
  logic [DATA_W-1:0] ao_q;
  logic [DATA_W-1:0] dm_q;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RA_W-1:0]   a3_h_q;
  logic [DATA_W-1:0] wd_h_q;
  logic              we_h_q;

  logic              retire;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       link32;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] wd;
  logic              grf_we;

  // Flush only kills the slot; the payload registers keep their old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      we_q      <= 1'b0;
      a3_q      <= '0;
      wd_src_q  <= '0;
      ld_type_q <= '0;
      ao_q      <= '0;
      dm_q      <= '0;
    end else if (flush_W) begin
      valid_q   <= 1'b0;
    end else if (!stall_W) begin
      valid_q   <= valid_M;
      pc_q      <= pc_M;
      we_q      <= we_M;
      a3_q      <= a3_M;
      wd_src_q  <= wd_src_M;
      ld_type_q <= ld_type_M;
      ao_q      <= ao_M;
      dm_q      <= dm_M;
    end
  end

  always_comb begin
    byte_v = 8'(dm_q >> {ao_q[LaneW-1:0], 3'b000});
    half_v = 16'(dm_q >> {ao_q[LaneW-1:1], 4'b0000});
    link32 = pc_q + 32'd8;
    case (ld_type_q)
      3'b001:  mem_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      3'b010:  mem_data = {{(DATA_W-8){1'b0}}, byte_v};
      3'b011:  mem_data = {{(DATA_W-16){half_v[15]}}, half_v};
      3'b100:  mem_data = {{(DATA_W-16){1'b0}}, half_v};
      default: mem_data = dm_q;
    endcase
    case (wd_src_q)
      2'b01:   wd = mem_data;
      2'b10:   wd = DATA_W'(link32);
      default: wd = ao_q;
    endcase
    grf_we = valid_q & we_q & (a3_q != '0);
  end

  // A stalled slot never retires, so a flush over a stall leaves count/history alone.
  assign retire = valid_q & ~stall_W;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a3_h_q <= '0;
      wd_h_q <= '0;
      we_h_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (retire) begin
        a3_h_q <= a3_q;
        wd_h_q <= wd;
        we_h_q <= grf_we;
      end
    end
  end

  assign A3_W     = a3_q;
  assign WD3_W    = wd;
  assign grf_we_W = grf_we;
  assign valid_W  = valid_q;
  assign A3_H     = a3_h_q;
  assign WD3_H    = wd_h_q;
  assign we_H     = we_h_q;
  assign retired  = cnt_q;

endmodule

// File: tb/tb_stage_wb_param.sv
// Directed self-checking bench for stage_wb_param (4-bit retire counter).
module tb_stage_wb_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_M;
  logic [31:0] pc_M;
  logic        we_M;
  logic [4:0]  a3_M;
  logic [1:0]  wd_src_M;
  logic [2:0]  ld_type_M;
  logic [31:0] ao_M;
  logic [31:0] dm_M;
  logic        stall_W;
  logic        flush_W;
  logic        clr_cnt;
  logic [4:0]  A3_W;
  logic [31:0] WD3_W;
  logic        grf_we_W;
  logic        valid_W;
  logic [4:0]  A3_H;
  logic [31:0] WD3_H;
  logic        we_H;
  logic [3:0]  retired;

  int n_checks = 0;
  int n_errors = 0;
  logic       exp_valid = 1'b0;
  logic [3:0] exp_cnt   = 4'd0;

  stage_wb_param #(
    .DATA_W(32),
    .RA_W  (5),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_M  (valid_M),
    .pc_M     (pc_M),
    .we_M     (we_M),
    .a3_M     (a3_M),
    .wd_src_M (wd_src_M),
    .ld_type_M(ld_type_M),
    .ao_M     (ao_M),
    .dm_M     (dm_M),
    .stall_W  (stall_W),
    .flush_W  (flush_W),
    .clr_cnt  (clr_cnt),
    .A3_W     (A3_W),
    .WD3_W    (WD3_W),
    .grf_we_W (grf_we_W),
    .valid_W  (valid_W),
    .A3_H     (A3_H),
    .WD3_H    (WD3_H),
    .we_H     (we_H),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one posedge, tracking the expected valid slot and retire count.
  task automatic tick();
    @(posedge clk);
    if (clr_cnt) exp_cnt = 4'd0;
    else if (exp_valid && !stall_W) exp_cnt = exp_cnt + 4'd1;
    if (flush_W) exp_valid = 1'b0;
    else if (!stall_W) exp_valid = valid_M;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] a3,
                       input logic [1:0] src, input logic [2:0] ld, input logic [31:0] ao,
                       input logic [31:0] dm);
    valid_M = v; pc_M = pc; we_M = we; a3_M = a3;
    wd_src_M = src; ld_type_M = ld; ao_M = ao; dm_M = dm;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(valid_W), 64'd0);
    check_eq({tag, "_we"}, 64'(grf_we_W), 64'd0);
    check_eq({tag, "_a3"}, 64'(A3_W), 64'd0);
    check_eq({tag, "_wd"}, 64'(WD3_W), 64'd0);
    check_eq({tag, "_a3h"}, 64'(A3_H), 64'd0);
    check_eq({tag, "_wdh"}, 64'(WD3_H), 64'd0);
    check_eq({tag, "_weh"}, 64'(we_H), 64'd0);
    check_eq({tag, "_ret"}, 64'(retired), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_W = 1'b0; flush_W = 1'b0; clr_cnt = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
    #3;
    check_all_zero("reset");
    #9 rst_n = 1'b1;

    // lb, ao=..01, dm=0x0000_8000
    drive(1'b1, 32'h0000_1000, 1'b1, 5'd5, 2'b01, 3'b001, 32'h0000_0101, 32'h0000_8000);
    tick();
    check_eq("lb_wd", 64'(WD3_W), 64'hFFFF_FF80);
    check_eq("lb_a3", 64'(A3_W), 64'd5);
    check_eq("lb_we", 64'(grf_we_W), 64'd1);
    check_eq("lb_ret", 64'(retired), 64'd0);

    drive(1'b1, 32'h0000_1004, 1'b1, 5'd5, 2'b01, 3'b010, 32'h0000_0101, 32'h0000_8000);
    tick();
    check_eq("lbu_wd", 64'(WD3_W), 64'h0000_0080);
    check_eq("lbu_hist_a3", 64'(A3_H), 64'd5);
    check_eq("lbu_hist_wd", 64'(WD3_H), 64'hFFFF_FF80);
    check_eq("lbu_ret", 64'(retired), 64'd1);

    drive(1'b1, 32'h0000_1008, 1'b1, 5'd6, 2'b01, 3'b011, 32'h0000_0202, 32'h8001_0000);
    tick();
    check_eq("lh_wd", 64'(WD3_W), 64'hFFFF_8001);

    // Link write to r0: data pc+8 wraps, write enable suppressed
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd0, 2'b10, 3'b000, 32'h0, 32'h0);
    tick();
    check_eq("link_wd", 64'(WD3_W), 64'h0000_0004);
    check_eq("link_we_r0", 64'(grf_we_W), 64'd0);
    check_eq("link_valid", 64'(valid_W), 64'd1);
    check_eq("link_hist_wd", 64'(WD3_H), 64'hFFFF_8001);

    // ALU write held over a 3-cycle stall
    drive(1'b1, 32'h0000_2000, 1'b1, 5'd7, 2'b00, 3'b000, 32'h1234_5678, 32'h0);
    tick();
    check_eq("alu_wd", 64'(WD3_W), 64'h1234_5678);
    check_eq("alu_ret", 64'(retired), 64'd4);
    check_eq("alu_hist_we", 64'(we_H), 64'd0);
    drive(1'b1, 32'h0000_2004, 1'b1, 5'd9, 2'b11, 3'b000, 32'h0000_DEAD, 32'h0);
    stall_W = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_wd", 64'(WD3_W), 64'h1234_5678);
      check_eq("stall_a3", 64'(A3_W), 64'd7);
      check_eq("stall_we", 64'(grf_we_W), 64'd1);
      check_eq("stall_ret", 64'(retired), 64'd4);
      check_eq("stall_hist_a3", 64'(A3_H), 64'd0);
    end
    stall_W = 1'b0;
    tick();
    check_eq("release_ret", 64'(retired), 64'd5);
    check_eq("release_hist_a3", 64'(A3_H), 64'd7);
    check_eq("release_hist_wd", 64'(WD3_H), 64'h1234_5678);
    check_eq("release_hist_we", 64'(we_H), 64'd1);
    check_eq("release_a3", 64'(A3_W), 64'd9);
    check_eq("release_wd11", 64'(WD3_W), 64'h0000_DEAD);

    // Flush over stall kills the slot without retiring it
    stall_W = 1'b1; flush_W = 1'b1;
    tick();
    check_eq("flush_valid", 64'(valid_W), 64'd0);
    check_eq("flush_we", 64'(grf_we_W), 64'd0);
    check_eq("flush_ret", 64'(retired), 64'd5);
    check_eq("flush_hist_a3", 64'(A3_H), 64'd7);
    stall_W = 1'b0; flush_W = 1'b0; valid_M = 1'b0;
    tick();
    check_eq("bubble_ret", 64'(retired), 64'd5);
    check_eq("bubble_hist_wd", 64'(WD3_H), 64'h1234_5678);

    // 17 retires on a 4-bit counter wrap to 1
    clr_cnt = 1'b1;
    drive(1'b1, 32'h0000_3000, 1'b1, 5'd1, 2'b00, 3'b000, 32'h0000_0011, 32'h0);
    tick();
    check_eq("clr_ret", 64'(retired), 64'd0);
    clr_cnt = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check_eq("wrap_ret", 64'(retired), 64'd1);
    check_eq("wrap_model", 64'(retired), 64'(exp_cnt));
    clr_cnt = 1'b1;
    tick();
    check_eq("clr_wins", 64'(retired), 64'd0);
    clr_cnt = 1'b0;

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 32'h0000_4000, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0000_0055, 32'h0);
    tick();
    stall_W = 1'b1;
    tick();
    check_eq("prerst_a3", 64'(A3_W), 64'd3);
    #2 rst_n = 1'b0;
    exp_valid = 1'b0; exp_cnt = 4'd0;
    #1;
    check_all_zero("async_rst");
    stall_W = 1'b0;
    drive(1'b1, 32'h0000_5000, 1'b1, 5'd4, 2'b00, 3'b000, 32'h0A0B_0C0D, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check_eq("post_rst_valid", 64'(valid_W), 64'd1);
    check_eq("post_rst_a3", 64'(A3_W), 64'd4);
    check_eq("post_rst_wd", 64'(WD3_W), 64'h0A0B_0C0D);
    check_eq("post_rst_ret", 64'(retired), 64'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_wb_param.md
STAGE_WB_PARAM -- requirements
Module: stage_wb_param

Interface
REQ-001 Parameter DATA_W, default 32: datapath width; SHALL be a power of two, 32 or greater.
REQ-002 Parameter RA_W, default 5: register-address width.
REQ-003 Parameter CNT_W, default 32: retire-counter width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 valid_M  input  1  the MM-stage slot holds a real instruction.
REQ-007 pc_M  input  32  PC of the MM instruction.
REQ-008 we_M  input  1  the instruction writes the GRF.
REQ-009 a3_M  input  RA_W  destination register.
REQ-010 wd_src_M  input  2  write-data source: 00 ALU, 01 memory, 10 link (PC+8), 11 ALU.
REQ-011 ld_type_M  input  3  load type: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned, others word.
REQ-012 ao_M  input  DATA_W  ALU result or load address.
REQ-013 dm_M  input  DATA_W  raw memory read word.
REQ-014 stall_W  input  1  hold the W stage.
REQ-015 flush_W  input  1  insert a bubble into the W stage.
REQ-016 clr_cnt  input  1  synchronous clear of the retire counter.
REQ-017 A3_W  output  RA_W  write address.
REQ-018 WD3_W  output  DATA_W  write data.
REQ-019 grf_we_W  output  1  GRF write enable.
REQ-020 valid_W  output  1  W slot valid.
REQ-021 A3_H, WD3_H, we_H  output  RA_W/DATA_W/1  previous-retire history for bypass.
REQ-022 retired  output  CNT_W  count of retired instructions.

Function
REQ-023 On each posedge, the W registers (valid, pc, we, a3, wd_src, ld_type, ao, dm) SHALL load from the _M inputs when stall_W=0 and flush_W=0.
REQ-024 When flush_W=1, valid_W SHALL become 0 and the other W registers SHALL be don't-care; flush SHALL take priority over stall.
REQ-025 When stall_W=1 and flush_W=0, all W registers SHALL hold their values.
REQ-026 WD3_W SHALL be combinational from the W registers, valid in the same cycle the instruction is captured; total latency from the _M inputs is one cycle.
REQ-027 Lane select: byte lane = ao[log2(DATA_W/8)-1:0]; half lane = ao[log2(DATA_W/8)-1:1], with ao[0] ignored on half loads.
REQ-028 Memory data: byte and half loads SHALL sign- or zero-extend to DATA_W according to ld_type; word loads SHALL pass dm unchanged.
REQ-029 Link data SHALL be pc+8, zero-extended to DATA_W, with 32-bit wrap-around.
REQ-030 grf_we_W SHALL equal valid_W & we_W & (A3_W!=0); it remains asserted during a stall.
REQ-031 Retire event = valid_W & ~stall_W at a posedge; retired SHALL increment by one per event and wrap from 2^CNT_W-1 to 0.
REQ-032 clr_cnt=1 SHALL set retired to 0 at the posedge; clear SHALL win over a simultaneous retire.
REQ-033 On a retire event, A3_H, WD3_H and we_H SHALL capture A3_W, WD3_W and grf_we_W; otherwise they SHALL hold.
REQ-034 A flush of a stalled valid instruction SHALL NOT count as a retire and SHALL NOT update the history registers.

Reset
REQ-035 rst_n=0 SHALL immediately clear valid_W, all W registers, A3_H, WD3_H, we_H and retired to 0, independent of clk.
REQ-036 During reset, grf_we_W=0, A3_W=0 and WD3_W=0.
REQ-037 Reset asserted mid-stall SHALL discard the held instruction; the first capture after release SHALL occur at the first posedge with rst_n=1.

Verification
REQ-038 Bench: lb with dm=0x0000_8000, ao=...01 -> WD3_W=0xFFFF_FF80; lbu -> 0x0000_0080; lh with ao=...2 and dm=0x8001_0000 -> 0xFFFF_8001.
REQ-039 Bench: link with pc_M=0xFFFF_FFFC -> WD3_W=0x0000_0004; we_M=1, a3_M=0 -> grf_we_W=0.
REQ-040 Bench: stall_W=1 for 3 cycles on a valid ALU write -> outputs held, retired increments once, history updates once after release.
REQ-041 Bench: stall_W=1 and flush_W=1 together -> valid_W=0 next cycle, retired unchanged, history unchanged.
REQ-042 Bench: CNT_W=4 with 17 retires -> retired=1; clr_cnt coincident with a retire -> retired=0.
REQ-043 Bench: rst_n low between clock edges mid-stream -> all outputs 0 immediately; first instruction after release is captured correctly.
